// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared state type, counter sizing helper and default timing
// constants for the reset sequencer and its optional watchdog
// (RSTSEQ_WDT_EN).
package rst_seq_pkg;

    // Sequencer states.
    //   HOLD    | every domain held in reset, stretching the reset source
    //   RELEASE | domains 1..STAGES-1 being released one per gap
    //   RUN     | all domains released, accepting software/watchdog resets
    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } rst_seq_state_t;

    localparam int RSTSEQ_HOLD_DEF = 16;
    localparam int RSTSEQ_GAP_DEF  = 4;
    localparam int RSTSEQ_WDT_DEF  = 1024;

    // Width of the shared sequencing counter. It must be able to hold the
    // largest of the three timing parameters.
    function automatic int cnt_width(input int hold, input int gap, input int wdt);
        int m;
        m = hold;
        if (gap > m) m = gap;
        if (wdt > m) m = wdt;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rst_seq_wdt.sv
// rst_seq_wdt: watchdog for the reset sequencer. Counts edges spent in RUN,
// clears on a kick or whenever the sequencer is not in RUN, and raises a
// sticky flag on expiry. Only instantiated when RSTSEQ_WDT_EN is defined.
module rst_seq_wdt #(
    parameter int WDT_CYCLES = 1024
) (
    input  logic CLK,
    input  logic RST,
    input  logic RUN,
    input  logic KICK,
    output logic EXPIRE,
    output logic FLAG
);

    localparam int WW = $clog2(WDT_CYCLES + 1);

    logic [WW-1:0] wcnt_q;
    logic          flag_q;

    // Expiry fires on the edge the count reaches WDT_CYCLES-1 unless a kick
    // arrives on that same edge.
    assign EXPIRE = RUN && !KICK && (wcnt_q == WW'(WDT_CYCLES - 1));
    assign FLAG   = flag_q;

    // Edge counter: only advances in RUN; cleared on kick, expiry or outside RUN.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wcnt_q <= '0;
        end else if (!RUN || KICK || EXPIRE) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_q + WW'(1);
        end
    end

    // Sticky expiry flag; only the hard reset clears it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            flag_q <= 1'b0;
        end else if (EXPIRE) begin
            flag_q <= 1'b1;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: stretches a raw active-high reset into a minimum hold,
// then releases STAGES active-low reset domains in order with a fixed gap.
// Software reset requests are taken over a req/ack handshake while in RUN.
// Defining RSTSEQ_WDT_EN adds the WDT_KICK port and a watchdog that re-enters
// the sequence on expiry; otherwise WDT_FLAG is tied low.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int STAGES      = 3,
    parameter int HOLD_CYCLES = RSTSEQ_HOLD_DEF,
    parameter int GAP_CYCLES  = RSTSEQ_GAP_DEF,
    parameter int WDT_CYCLES  = RSTSEQ_WDT_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SW_RST_REQ,
`ifdef RSTSEQ_WDT_EN
    input  logic              WDT_KICK,
`endif
    output logic [STAGES-1:0] RST_OUT_,
    output logic              RST_DONE,
    output logic              SW_RST_ACK,
    output logic              WDT_FLAG
);

    localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES, WDT_CYCLES);
    localparam int SW = $clog2(STAGES + 1);

    if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
        $error("reset_sequencer: STAGES must be in 1..8");
    end
    if (HOLD_CYCLES < 2) begin : g_bad_hold
        $error("reset_sequencer: HOLD_CYCLES must be at least 2");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("reset_sequencer: GAP_CYCLES must be at least 1");
    end

    rst_seq_state_t    state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     stage_q, stage_d;
    logic [STAGES-1:0] out_q, out_d;
    logic              done_q, done_d;
    logic              ack_q, ack_d;
    logic              req_q;
    logic              in_run;
    logic              sw_hit;
    logic              wdt_expire;

    assign in_run = (state_q == RUN);
    assign sw_hit = in_run && req_q;

`ifdef RSTSEQ_WDT_EN
    rst_seq_wdt #(
        .WDT_CYCLES(WDT_CYCLES)
    ) u_wdt (
        .CLK    (CLK),
        .RST    (RST),
        .RUN    (in_run),
        .KICK   (WDT_KICK),
        .EXPIRE (wdt_expire),
        .FLAG   (WDT_FLAG)
    );
`else
    assign wdt_expire = 1'b0;
    assign WDT_FLAG   = 1'b0;
`endif

    // Software request sampler: a request only counts if seen while in RUN,
    // so requests raised during HOLD/RELEASE are dropped rather than queued.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            req_q <= 1'b0;
        end else begin
            req_q <= SW_RST_REQ && in_run;
        end
    end

    // State, counter, stage index and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            stage_q <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            out_q   <= out_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
        end
    end

    // Next-state logic: hold stretch, ordered release, then restart on
    // software request or watchdog expiry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        out_d   = out_q;
        done_d  = done_q;
        ack_d   = 1'b0;

        case (state_q)
            HOLD: begin
                if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                    out_d[0] = 1'b1;
                    cnt_d    = '0;
                    stage_d  = SW'(1);
                    if (STAGES == 1) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            RELEASE: begin
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    for (int i = 1; i < STAGES; i++) begin
                        if (stage_q == SW'(i)) begin
                            out_d[i] = 1'b1;
                        end
                    end
                    stage_d = stage_q + SW'(1);
                    cnt_d   = '0;
                    if (stage_q == SW'(STAGES - 1)) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            RUN: begin
                if (sw_hit || wdt_expire) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    stage_d = '0;
                    out_d   = '0;
                    done_d  = 1'b0;
                    ack_d   = sw_hit;
                end
            end

            default: begin
                state_d = HOLD;
                cnt_d   = '0;
                stage_d = '0;
                out_d   = '0;
                done_d  = 1'b0;
            end
        endcase
    end

    assign RST_OUT_   = out_q;
    assign RST_DONE   = done_q;
    assign SW_RST_ACK = ack_q;

endmodule
